// File: rtl/wb_uart_loader.sv
// wb_uart_loader: UART-driven Wishbone initiator for debug / firmware load.
// Parses 'W' (write word) and 'R' (read word) packets from the UART receiver.
// Each packet becomes one Wishbone classic cycle. The result is returned as
// bytes to the UART transmitter: 'K' for a write, 4 data bytes LSB first for
// a read, or 'E' if the cycle timed out.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rx_data/rx_valid        received byte stream (no backpressure)
//   tx_data/tx_valid/tx_ready  response byte stream (valid/ready)
//   wb_*                    Wishbone classic initiator port
//   busy                    high whenever the FSM is not idle
module wb_uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  output logic        busy
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic             we_q, we_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      wdata_q, wdata_n;
  logic [31:0]      resp_q, resp_n;
  logic [7:0]       tx_data_n;
  logic             tx_valid_n;
  logic             cyc_n;

  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;
  assign wb_stb   = wb_cyc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 2'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_sel   <= 4'h0;
      wb_we    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      we_q     <= we_n;
      err_q    <= err_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      resp_q   <= resp_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      wb_cyc   <= cyc_n;
      wb_sel   <= cyc_n ? 4'hF : 4'h0;
      wb_we    <= cyc_n & we_n;
      busy     <= (state_n != IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    we_n       = we_q;
    err_n      = err_q;
    cnt_n      = cnt;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    resp_n     = resp_q;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    cyc_n      = wb_cyc;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            we_n    = (rx_data == CMD_WRITE);
            err_n   = 1'b0;
            idx_n   = 2'd0;
            state_n = ADDR;
          end
        end
      end

      ADDR: begin
        if (rx_valid) begin
          addr_n[{idx, 3'b000} +: 8] = rx_data;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
            if (we_q) begin
              state_n = DATA;
            end else begin
              state_n = BUS;
              cyc_n   = 1'b1;
              cnt_n   = '0;
            end
          end
        end
      end

      DATA: begin
        if (rx_valid) begin
          wdata_n[{idx, 3'b000} +: 8] = rx_data;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
            state_n = BUS;
            cyc_n   = 1'b1;
            cnt_n   = '0;
          end
        end
      end

      BUS: begin
        idx_n = 2'd0;
        // Ack wins over a timeout expiring on the same edge
        if (wb_ack) begin
          cyc_n      = 1'b0;
          tx_valid_n = 1'b1;
          state_n    = RESP;
          if (we_q) begin
            tx_data_n = RESP_OK;
          end else begin
            resp_n    = wb_rdata;
            tx_data_n = wb_rdata[7:0];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt_n == TIMEOUT) begin
            cyc_n      = 1'b0;
            err_n      = 1'b1;
            tx_valid_n = 1'b1;
            tx_data_n  = RESP_ERR;
            state_n    = RESP;
          end
        end
      end

      RESP: begin
        if (tx_valid && tx_ready) begin
          if (err_q || we_q || idx == 2'd3) begin
            tx_valid_n = 1'b0;
            idx_n      = 2'd0;
            err_n      = 1'b0;
            state_n    = IDLE;
          end else begin
            // Read data shifts down so the next byte is always at [15:8]
            idx_n     = idx + 2'd1;
            tx_data_n = resp_q[15:8];
            resp_n    = resp_q >> 8;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
